// File: rtl/tsu_queue_arb_pkg.sv
// tsu_queue_arb_pkg
//   Shared definitions for the tsu queue aggregator:
//   - arb_state_e : arbiter FSM states (IDLE/ISSUE/CAPTURE)
//   - ch_id_w()   : width of the channel-id tag prepended to each entry
//   - DROP_CNT_W  : width of the saturating drop counter
package tsu_queue_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_e;

  localparam int DROP_CNT_W = 16;

  // Channel-id width; never zero so the tag field always exists.
  function automatic int ch_id_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tsu_queue_arb_fifo.sv
// tsu_queue_arb_fifo
//   Synchronous FIFO with registered read data, matching tsu queue read
//   semantics (data appears the cycle after an accepted read).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en, wr_data    write request; accepted when not full, or when full
//                     and a pop happens on the same edge
//   rd_en             read strobe; ignored while empty
//   rd_data           registered read data, holds when no pop
//   count             fill count (0..DEPTH)
//   full, empty       status flags
module tsu_queue_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push, pop;

  // Extra MSB on the pointers distinguishes full from empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign pop  = rd_en & ~empty;
  // A full FIFO still accepts a write when the same edge frees a slot; the
  // read below samples the old cell contents, so the overlap is safe.
  assign push = wr_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/tsu_queue_arb.sv
// tsu_queue_arb
//   Drains NCH upstream tsu timestamp queues in round-robin order, tags each
//   entry with its channel id and buffers it in a local FIFO read by the host.
//   One entry is moved every 3 cycles (IDLE -> ISSUE -> CAPTURE).
// Ports:
//   q_rd_clk, q_rst_n  clock, synchronous active-low reset
//   ch_rd_en           one-hot upstream read strobe (registered)
//   ch_rd_stat         per-channel upstream fill count, ch i at [i*SW +: SW]
//   ch_rd_data         per-channel upstream data, valid cycle after ch_rd_en
//   out_rd_en          host read strobe
//   out_rd_stat        local FIFO fill count
//   out_rd_data        {channel id, entry}, valid cycle after accepted read
//   drop_cnt           saturating dropped-entry count
// Build option:
//   TSU_QUEUE_ARB_DROP_EN  keep draining upstream while the FIFO is full and
//                          discard (and count) entries that find no slot.
//                          Without it the full FIFO backpressures upstream and
//                          drop_cnt reads 0.
module tsu_queue_arb
  import tsu_queue_arb_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = 128,
  parameter int SW    = 8,
  parameter int DEPTH = 16,
  localparam int CW   = ch_id_w(NCH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  q_rd_clk,
  input  logic                  q_rst_n,
  output logic [NCH-1:0]        ch_rd_en,
  input  logic [NCH*SW-1:0]     ch_rd_stat,
  input  logic [NCH*DW-1:0]     ch_rd_data,
  input  logic                  out_rd_en,
  output logic [AW:0]           out_rd_stat,
  output logic [CW+DW-1:0]      out_rd_data,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [NCH-1:0][SW-1:0] stat_a;
  logic [NCH-1:0][DW-1:0] data_a;
  logic [NCH-1:0]         ch_req;

  assign stat_a = ch_rd_stat;
  assign data_a = ch_rd_data;

  for (genvar g = 0; g < NCH; g++) begin : g_req
    assign ch_req[g] = |stat_a[g];
  end

  arb_state_e    state;
  logic [CW-1:0] rr_ptr, grant;
  logic [CW-1:0] nxt_grant;
  logic          nxt_found;
  logic          slot_ok;
  logic          cap_wr;
  logic          fifo_full;

  // Round-robin search starting just after the last grant, wrapping mod NCH.
  always_comb begin
    logic [CW-1:0] idx;
    nxt_found = 1'b0;
    nxt_grant = '0;
    idx       = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(rr_ptr) + k) % NCH);
      if (!nxt_found && ch_req[idx]) begin
        nxt_found = 1'b1;
        nxt_grant = idx;
      end
    end
  end

`ifdef TSU_QUEUE_ARB_DROP_EN
  assign slot_ok = 1'b1;
`else
  // Count is sampled before this cycle's host read; a concurrent pop only
  // makes room, so the check is conservative.
  assign slot_ok = ~fifo_full;
`endif

  always_ff @(posedge q_rd_clk) begin
    if (!q_rst_n) begin
      state    <= IDLE;
      ch_rd_en <= '0;
      rr_ptr   <= CW'(NCH-1);
      grant    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (nxt_found && slot_ok) begin
            state    <= ISSUE;
            grant    <= nxt_grant;
            rr_ptr   <= nxt_grant;
            ch_rd_en <= NCH'(1) << nxt_grant;
          end
        end
        ISSUE: begin
          ch_rd_en <= '0;
          state    <= CAPTURE;
        end
        CAPTURE: state <= IDLE;
        default: begin
          ch_rd_en <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign cap_wr = (state == CAPTURE);

  tsu_queue_arb_fifo #(
    .W     (CW+DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (q_rd_clk),
    .rst_n   (q_rst_n),
    .wr_en   (cap_wr),
    .wr_data ({grant, data_a[grant]}),
    .rd_en   (out_rd_en),
    .rd_data (out_rd_data),
    .count   (out_rd_stat),
    .full    (fifo_full),
    .empty   ()
  );

`ifdef TSU_QUEUE_ARB_DROP_EN
  logic [DROP_CNT_W-1:0] drop_q;

  // A full FIFO is never empty, so out_rd_en alone means a pop this edge,
  // which frees the slot the capture lands in.
  always_ff @(posedge q_rd_clk) begin
    if (!q_rst_n)
      drop_q <= '0;
    else if (cap_wr && fifo_full && !out_rd_en && (drop_q != '1))
      drop_q <= drop_q + DROP_CNT_W'(1);
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_tsu_queue_arb.sv
module tb_tsu_queue_arb;

  localparam int NCH   = 4;
  localparam int DW    = 128;
  localparam int SW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int AW    = 4;

  logic                q_rd_clk = 1'b0;
  logic                q_rst_n;
  logic [NCH-1:0]      ch_rd_en;
  logic [NCH*SW-1:0]   ch_rd_stat;
  logic [NCH*DW-1:0]   ch_rd_data = '0;
  logic                out_rd_en;
  logic [AW:0]         out_rd_stat;
  logic [CW+DW-1:0]    out_rd_data;
  logic [15:0]         drop_cnt;

  always #5 q_rd_clk = ~q_rd_clk;

  tsu_queue_arb #(.NCH(NCH), .DW(DW), .SW(SW), .DEPTH(DEPTH)) dut (
    .q_rd_clk    (q_rd_clk),
    .q_rst_n     (q_rst_n),
    .ch_rd_en    (ch_rd_en),
    .ch_rd_stat  (ch_rd_stat),
    .ch_rd_data  (ch_rd_data),
    .out_rd_en   (out_rd_en),
    .out_rd_stat (out_rd_stat),
    .out_rd_data (out_rd_data),
    .drop_cnt    (drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Upstream queue model: entries pushed by the tests, consumed one per
  // ch_rd_en pulse, data presented on the edge after the pulse.
  int              push_cnt [NCH];
  int              pop_cnt  [NCH];
  logic [DW-1:0]   dbase    [NCH];
  logic [NCH-1:0]  pend = '0;

  for (genvar g = 0; g < NCH; g++) begin : g_stat
    assign ch_rd_stat[g*SW +: SW] = SW'(push_cnt[g] - pop_cnt[g]);
  end

  function automatic logic [DW-1:0] up_data(input int ch, input int seq);
    return dbase[ch] + DW'(seq);
  endfunction

  logic [CW+DW-1:0] exp_q[$];
  logic [CW+DW-1:0] rd_log[$];
  int               grant_q[$];
  int               pulse_cnt = 0;
  int               bad_onehot = 0;
  logic [CW+DW-1:0] last_rd = '0;

  // Scoreboard producer: every strobe seen pushes the entry that channel
  // will deliver, tagged with the channel id.
  always @(negedge q_rd_clk) begin
    pend = ch_rd_en;
    if (ch_rd_en != '0) begin
      pulse_cnt++;
      if ($countones(ch_rd_en) != 1) bad_onehot++;
      for (int i = 0; i < NCH; i++)
        if (ch_rd_en[i]) begin
          grant_q.push_back(i);
          exp_q.push_back({CW'(i), up_data(i, pop_cnt[i])});
        end
    end
  end

  always @(posedge q_rd_clk) begin
    for (int i = 0; i < NCH; i++)
      if (pend[i]) begin
        ch_rd_data[i*DW +: DW] <= up_data(i, pop_cnt[i]);
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
  end

  task automatic tick();
    @(negedge q_rd_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    q_rst_n   = 1'b0;
    out_rd_en = 1'b0;
    ticks(2);
    q_rst_n = 1'b1;
    exp_q.delete();
    grant_q.delete();
  endtask

  task automatic host_read(output logic [CW+DW-1:0] d);
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    d = out_rd_data;
    last_rd = d;
  endtask

  // Read everything the DUT produces until it has been quiet for a while.
  task automatic drain();
    int idle;
    logic [CW+DW-1:0] d;
    idle = 0;
    rd_log.delete();
    for (int c = 0; c < 400 && idle < 6; c++) begin
      if (out_rd_stat != '0) begin
        host_read(d);
        rd_log.push_back(d);
        idle = 0;
      end else begin
        tick();
        idle++;
      end
    end
  endtask

  task automatic test_reset();
    q_rst_n   = 1'b0;
    out_rd_en = 1'b0;
    ticks(2);
    checks++; if (ch_rd_en !== 4'b0000) begin failures++; $display("FAIL reset_ch_rd_en got=%b exp=0000", ch_rd_en); end
    checks++; if (out_rd_stat !== 5'd0) begin failures++; $display("FAIL reset_out_rd_stat got=%0d exp=0", out_rd_stat); end
    checks++; if (out_rd_data !== '0) begin failures++; $display("FAIL reset_out_rd_data got=%h exp=0", out_rd_data); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    q_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base;
    logic [CW+DW-1:0] d, e;
    base = pulse_cnt;
    dbase[2] = 128'hA5;
    push_cnt[2]++;
    tick();
    checks++; if (ch_rd_en !== 4'b0100) begin failures++; $display("FAIL single_strobe got=%b exp=0100", ch_rd_en); end
    ticks(2);
    checks++; if (out_rd_stat !== 5'd1) begin failures++; $display("FAIL single_stat got=%0d exp=1", out_rd_stat); end
    ticks(4);
    checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulse_cnt - base); end
    host_read(d);
    checks++; if (d !== {2'd2, 128'hA5}) begin failures++; $display("FAIL single_data got=%h exp=%h", d, {2'd2, 128'hA5}); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    checks++; if (d !== e) begin failures++; $display("FAIL single_scoreboard got=%h exp=%h", d, e); end
  endtask

  task automatic test_round_robin();
    int base;
    logic [CW+DW-1:0] e;
    do_reset();
    base = pulse_cnt;
    for (int i = 0; i < NCH; i++) push_cnt[i] += 2;
    for (int c = 0; c < 100 && pulse_cnt - base < 8; c++) tick();
    ticks(4);
    checks++; if (grant_q.size() !== 8) begin failures++; $display("FAIL rr_grant_count got=%0d exp=8", grant_q.size()); end
    for (int k = 0; k < 8 && k < grant_q.size(); k++) begin
      checks++; if (grant_q[k] !== k % NCH) begin failures++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, grant_q[k], k % NCH); end
    end
    drain();
    checks++; if (rd_log.size() !== 8) begin failures++; $display("FAIL rr_read_count got=%0d exp=8", rd_log.size()); end
    for (int k = 0; k < rd_log.size(); k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++; if (rd_log[k] !== e || rd_log[k][CW+DW-1:DW] !== CW'(k % NCH))
        begin failures++; $display("FAIL rr_read_%0d got=%h exp=%h", k, rd_log[k], e); end
    end
  endtask

`ifndef TSU_QUEUE_ARB_DROP_EN
  task automatic test_backpressure();
    int base;
    logic [CW+DW-1:0] d, e;
    do_reset();
    base = pulse_cnt;
    push_cnt[0] += 20;
    ticks(120);
    checks++; if (pulse_cnt - base !== 16) begin failures++; $display("FAIL bp_pulses got=%0d exp=16", pulse_cnt - base); end
    checks++; if (out_rd_stat !== 5'd16) begin failures++; $display("FAIL bp_full_stat got=%0d exp=16", out_rd_stat); end
    host_read(d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    checks++; if (d !== e) begin failures++; $display("FAIL bp_first_read got=%h exp=%h", d, e); end
    ticks(20);
    checks++; if (pulse_cnt - base !== 17) begin failures++; $display("FAIL bp_pulses_after_read got=%0d exp=17", pulse_cnt - base); end
    checks++; if (out_rd_stat !== 5'd16) begin failures++; $display("FAIL bp_refill_stat got=%0d exp=16", out_rd_stat); end
    drain();
    checks++; if (rd_log.size() !== 19) begin failures++; $display("FAIL bp_drain_count got=%0d exp=19", rd_log.size()); end
    for (int k = 0; k < rd_log.size(); k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++; if (rd_log[k] !== e) begin failures++; $display("FAIL bp_drain_%0d got=%h exp=%h", k, rd_log[k], e); end
    end
  endtask
`else
  task automatic test_drop();
    int base;
    do_reset();
    push_cnt[0] += 16;
    ticks(80);
    checks++; if (out_rd_stat !== 5'd16) begin failures++; $display("FAIL drop_fill_stat got=%0d exp=16", out_rd_stat); end
    base = pulse_cnt;
    push_cnt[1] += 5;
    ticks(60);
    checks++; if (pulse_cnt - base !== 5) begin failures++; $display("FAIL drop_pulses got=%0d exp=5", pulse_cnt - base); end
    checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL drop_cnt got=%0d exp=5", drop_cnt); end
    checks++; if (out_rd_stat !== 5'd16) begin failures++; $display("FAIL drop_stat got=%0d exp=16", out_rd_stat); end
    drain();
    checks++; if (rd_log.size() !== 16) begin failures++; $display("FAIL drop_drain_count got=%0d exp=16", rd_log.size()); end
    for (int k = 0; k < rd_log.size() && k < exp_q.size(); k++) begin
      checks++; if (rd_log[k] !== exp_q[k]) begin failures++; $display("FAIL drop_drain_%0d got=%h exp=%h", k, rd_log[k], exp_q[k]); end
    end
    exp_q.delete();
  endtask
`endif

  task automatic test_empty_read();
    logic [CW+DW-1:0] prev, d, e;
    bit seen;
    prev = last_rd;
    host_read(d);
    checks++; if (d !== prev) begin failures++; $display("FAIL empty_read_hold got=%h exp=%h", d, prev); end
    checks++; if (out_rd_stat !== 5'd0) begin failures++; $display("FAIL empty_read_stat got=%0d exp=0", out_rd_stat); end
    last_rd = prev;
    push_cnt[3]++;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = (ch_rd_en != '0);
    end
    checks++; if (!seen) begin failures++; $display("FAIL empty_wr_strobe_timeout got=none exp=strobe"); end
    tick();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    checks++; if (out_rd_stat !== 5'd1) begin failures++; $display("FAIL empty_wr_stat got=%0d exp=1", out_rd_stat); end
    checks++; if (out_rd_data !== prev) begin failures++; $display("FAIL empty_wr_hold got=%h exp=%h", out_rd_data, prev); end
    host_read(d);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    checks++; if (d !== e || d[CW+DW-1:DW] !== 2'd3) begin failures++; $display("FAIL empty_wr_data got=%h exp=%h", d, e); end
  endtask

  task automatic test_reset_issue();
    logic [CW+DW-1:0] e;
    bit seen;
    do_reset();
    push_cnt[1] += 2;
    push_cnt[3] += 1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = (ch_rd_en != '0);
    end
    checks++; if (ch_rd_en !== 4'b0010) begin failures++; $display("FAIL rst_issue_pre_grant got=%b exp=0010", ch_rd_en); end
    q_rst_n = 1'b0;
    tick();
    checks++; if (ch_rd_en !== 4'b0000) begin failures++; $display("FAIL rst_issue_ch_rd_en got=%b exp=0000", ch_rd_en); end
    checks++; if (out_rd_stat !== 5'd0) begin failures++; $display("FAIL rst_issue_stat got=%0d exp=0", out_rd_stat); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_issue_drop got=%0d exp=0", drop_cnt); end
    q_rst_n = 1'b1;
    exp_q.delete();
    grant_q.delete();
    push_cnt[0] += 1;
    drain();
    checks++; if (grant_q.size() == 0 || grant_q[0] !== 0) begin failures++; $display("FAIL rst_issue_first_grant got=%0d exp=0", (grant_q.size() != 0) ? grant_q[0] : -1); end
    checks++; if (rd_log.size() !== 3) begin failures++; $display("FAIL rst_issue_read_count got=%0d exp=3", rd_log.size()); end
    for (int k = 0; k < rd_log.size(); k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++; if (rd_log[k] !== e) begin failures++; $display("FAIL rst_issue_read_%0d got=%h exp=%h", k, rd_log[k], e); end
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      push_cnt[i] = 0;
      pop_cnt[i]  = 0;
      dbase[i]    = {8'(8'h10 + i), 120'h0} + (DW'(i) << 32);
    end
    q_rst_n   = 1'b0;
    out_rd_en = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
`ifndef TSU_QUEUE_ARB_DROP_EN
    test_backpressure();
`else
    test_drop();
`endif
    test_empty_read();
    test_reset_issue();

    checks++; if (bad_onehot !== 0) begin failures++; $display("FAIL onehot_strobes got=%0d exp=0", bad_onehot); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
